// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with IF/ID register, stall skid buffer and branch redirect
// that drains an outstanding memory request before refetching.
module fetch_unit (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        BranchTaken,
   input  logic [7:0]  BranchOffset,
   output logic [15:0] IMemAddr,
   output logic        IMemReq,
   input  logic [15:0] IMemData,
   input  logic        IMemValid,
   output logic [15:0] Instruction,
   output logic [3:0]  OPCODE,
   output logic [15:0] PC_ID,
   output logic        Valid_ID
);
   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
   state_t state, state_nxt;
   logic [15:0] pc, pc_nxt, redirect, redirect_nxt, buffer, buffer_nxt;
   logic [15:0] instr_nxt, pc_id_nxt, target;
   logic valid_nxt;
   assign target = PC_ID + 16'd2 + {{7{BranchOffset[7]}}, BranchOffset, 1'b0};
   assign IMemAddr = pc;
   assign IMemReq = state != HOLD;
   assign OPCODE = Instruction[15:12];
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= FETCH;
         pc <= '0;
         redirect <= '0;
         buffer <= '0;
         Instruction <= '0;
         PC_ID <= '0;
         Valid_ID <= 1'b0;
      end else begin
         state <= state_nxt;
         pc <= pc_nxt;
         redirect <= redirect_nxt;
         buffer <= buffer_nxt;
         Instruction <= instr_nxt;
         PC_ID <= pc_id_nxt;
         Valid_ID <= valid_nxt;
      end
   end
   always_comb begin
      state_nxt = state;
      pc_nxt = pc;
      redirect_nxt = redirect;
      buffer_nxt = buffer;
      instr_nxt = Instruction;
      pc_id_nxt = PC_ID;
      valid_nxt = Valid_ID;
      if (BranchTaken) begin
         valid_nxt = 1'b0;
         buffer_nxt = '0;
         // Without a response in hand the request must complete before the target is fetched.
         if (state == HOLD || IMemValid) begin
            pc_nxt = target;
            state_nxt = FETCH;
         end else begin
            redirect_nxt = target;
            state_nxt = DRAIN;
         end
      end else if (state == FETCH) begin
         if (IMemValid && !Stall) begin
            instr_nxt = IMemData;
            pc_id_nxt = pc;
            valid_nxt = 1'b1;
            pc_nxt = pc + 16'd2;
         end else if (IMemValid) begin
            buffer_nxt = IMemData;
            state_nxt = HOLD;
         end else if (!Stall) begin
            valid_nxt = 1'b0;
         end
      end else if (state == HOLD) begin
         if (!Stall) begin
            instr_nxt = buffer;
            pc_id_nxt = pc;
            valid_nxt = 1'b1;
            pc_nxt = pc + 16'd2;
            state_nxt = FETCH;
         end
      end else if (IMemValid) begin
         pc_nxt = redirect;
         state_nxt = FETCH;
      end
   end
endmodule
